// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end.
//   fetch_state_e : fetch FSM encoding, also exported on the debug port
//   redirect_op_e : control-unit redirect opcodes
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_JMP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } redirect_op_e;

endpackage

// File: rtl/instr_fetch_unit_stack.sv
// ret_stack: LIFO of return addresses.
//   clk, arst_n : clock, synchronous active-low reset
//   push, pop   : push din / pop top entry (push-when-full and pop-when-empty
//                 are no-ops; the parent flags them)
//   clear       : empty the stack
//   din, dout   : push data / current top entry ('0 when empty)
//   full, empty : occupancy status
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    cnt;

  assign full  = (cnt == PW'(DEPTH));
  assign empty = (cnt == '0);

  // Top of stack lives at mem[cnt-1]; a compare mux avoids an index that
  // would be out of range when empty.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cnt == PW'(i + 1)) dout = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cnt == PW'(i)) mem[i] <= din;
      end
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches INSTR_BYTES flash bytes per instruction, packs
// them big-endian, and hands the word to the control unit over valid/ready.
// Handles JMP/CALL/RET through a return stack and a bootstrap address mask.
//   clk, arst_n                  : clock, synchronous active-low reset
//   flash_req/flash_addr         : one-cycle byte request and its address
//   flash_data/flash_ready       : returned byte and its strobe
//   instr/instr_valid/pc_out     : assembled instruction, valid, its address
//   instr_ready                  : control unit consumes instr
//   redirect_valid/op/target     : control-flow change, taken on handshake
//   boot_exit/bootstrapping      : leave bootstrap (restart at 0) / mode flag
//   stack_ovf/stack_unf          : sticky stack error flags
//   fetch_state                  : debug view of the FSM
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 12,
  parameter int unsigned           BYTE_WIDTH  = 8,
  parameter int unsigned           INSTR_BYTES = 2,
  parameter int unsigned           STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_MASK   = 'h07F
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [BYTE_WIDTH-1:0]             flash_data,
  input  logic                              flash_ready,
  output logic                              flash_req,
  output logic [ADDR_WIDTH-1:0]             flash_addr,
  output logic [BYTE_WIDTH*INSTR_BYTES-1:0] instr,
  output logic                              instr_valid,
  input  logic                              instr_ready,
  output logic [ADDR_WIDTH-1:0]             pc_out,
  input  logic                              redirect_valid,
  input  logic [1:0]                        redirect_op,
  input  logic [ADDR_WIDTH-1:0]             redirect_target,
  input  logic                              boot_exit,
  output logic                              bootstrapping,
  output logic                              stack_ovf,
  output logic                              stack_unf,
  output logic [1:0]                        fetch_state
);

  localparam int unsigned           IW    = BYTE_WIDTH * INSTR_BYTES;
  localparam int unsigned           CNT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'(INSTR_BYTES - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, seq_pc, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  boot_q, boot_d;
  logic [IW-1:0]         buf_q, asm_w;
  logic                  capture;
  logic                  push, pop, stk_clear, ovf_set, unf_set;
  logic [ADDR_WIDTH-1:0] stk_dout;
  logic                  stk_full, stk_empty;

  assign flash_req     = (state_q == REQ);
  assign fetch_state   = state_q;
  assign bootstrapping = boot_q;
  assign seq_pc        = pc_q + STEP;
  assign capture       = (state_q == WAIT) && flash_ready;

  ret_stack #(
    .DEPTH(STACK_DEPTH),
    .WIDTH(ADDR_WIDTH)
  ) u_stack (
    .clk   (clk),
    .arst_n(arst_n),
    .push  (push),
    .pop   (pop),
    .clear (stk_clear),
    .din   (seq_pc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    // Byte k lands at the k-th slot from the top (big-endian).
    asm_w = buf_q;
    for (int unsigned k = 0; k < INSTR_BYTES; k++) begin
      if (cnt_q == CNT_W'(k)) asm_w[(INSTR_BYTES-k)*BYTE_WIDTH-1 -: BYTE_WIDTH] = flash_data;
    end

    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    boot_d    = boot_q;
    push      = 1'b0;
    pop       = 1'b0;
    stk_clear = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    if (boot_exit) begin
      state_d   = REQ;
      pc_d      = '0;
      cnt_d     = '0;
      boot_d    = 1'b0;
      stk_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = WAIT;
        WAIT: begin
          if (flash_ready) begin
            if (cnt_q == LAST) begin
              state_d = HOLD;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = REQ;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = REQ;
            cnt_d   = '0;
            pc_d    = seq_pc;
            if (redirect_valid) begin
              case (redirect_op)
                OP_JMP:  pc_d = redirect_target;
                OP_CALL: begin
                  pc_d = redirect_target;
                  if (stk_full) ovf_set = 1'b1;
                  else          push    = 1'b1;
                end
                OP_RET: begin
                  if (stk_empty) begin
                    unf_set = 1'b1;
                  end else begin
                    pop  = 1'b1;
                    pc_d = stk_dout;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Address for the next request, computed from next-cycle pc/byte count
    // so the registered flash_addr is already correct in the REQ cycle.
    addr_d = pc_d + ADDR_WIDTH'(cnt_d);
    if (boot_d) addr_d = addr_d & BOOT_MASK;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      boot_q      <= 1'b1;
      buf_q       <= '0;
      flash_addr  <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      boot_q  <= boot_d;
      if (state_d == REQ) flash_addr <= addr_d;
      if (capture && !boot_exit) buf_q <= asm_w;
      if (boot_exit) begin
        instr_valid <= 1'b0;
      end else if (capture && (cnt_q == LAST)) begin
        instr       <= asm_w;
        instr_valid <= 1'b1;
        pc_out      <= pc_q;
      end else if ((state_q == HOLD) && instr_ready) begin
        instr_valid <= 1'b0;
      end
      if (ovf_set) stack_ovf <= 1'b1;
      if (unf_set) stack_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: flash responder model with configurable
// ready latency, scoreboard of expected {pc, instruction} fetches, a table of
// redirect vectors, and hand sequences for boot, stall/wrap and abort cases.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  flash_data;
  logic        flash_ready;
  logic        flash_req;
  logic [11:0] flash_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] pc_out;
  logic        redirect_valid;
  logic [1:0]  redirect_op;
  logic [11:0] redirect_target;
  logic        boot_exit;
  logic        bootstrapping;
  logic        stack_ovf, stack_unf;
  logic [1:0]  fetch_state;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_WIDTH (12),
    .BYTE_WIDTH (8),
    .INSTR_BYTES(2),
    .STACK_DEPTH(4),
    .BOOT_MASK  (12'h07F)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .flash_data     (flash_data),
    .flash_ready    (flash_ready),
    .flash_req      (flash_req),
    .flash_addr     (flash_addr),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_op    (redirect_op),
    .redirect_target(redirect_target),
    .boot_exit      (boot_exit),
    .bootstrapping  (bootstrapping),
    .stack_ovf      (stack_ovf),
    .stack_unf      (stack_unf),
    .fetch_state    (fetch_state)
  );

  // ---------------- flash model ----------------
  logic [7:0]  fmem [4096];
  logic [11:0] req_q [$];
  int          lat = 1;
  logic        inject_ready = 1'b0;

  initial begin
    int          pending;
    logic [11:0] cur_addr;
    for (int i = 0; i < 4096; i++) fmem[i] = 8'((i * 37) + 5);
    fmem[0] = 8'h12;
    fmem[1] = 8'h34;
    pending     = 0;
    cur_addr    = '0;
    flash_ready = 1'b0;
    flash_data  = '0;
    forever begin
      @(negedge clk);
      flash_ready = 1'b0;
      if (inject_ready) begin
        flash_ready = 1'b1;
        flash_data  = 8'hEE;
      end
      if (flash_req) begin
        req_q.push_back(flash_addr);
        cur_addr = flash_addr;
        pending  = lat;
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          flash_ready = 1'b1;
          flash_data  = fmem[cur_addr];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [11:0] pc;
    logic [15:0] word;
  } exp_t;

  typedef struct {
    logic        rv;
    logic [1:0]  op;
    logic [11:0] tgt;
    logic [11:0] nxt;
    logic        ovf;
    logic        unf;
  } vec_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   boot_m = 1'b1;

  function automatic logic [15:0] exp_word(input logic [11:0] pc, input bit boot);
    logic [11:0] a0, a1;
    a0 = pc;
    a1 = pc + 12'd1;
    if (boot) begin
      a0 = a0 & 12'h07F;
      a1 = a1 & 12'h07F;
    end
    return {fmem[a0], fmem[a1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = exp_word(pc, boot_m);
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!instr_valid && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!instr_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: instr_valid still 0 after %0d cycles", waited);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: instr 0x%0h pc 0x%0h with nothing expected", instr, pc_out);
    end else begin
      e = sb.pop_front();
      check("instr", 32'(instr), 32'(e.word));
      check("pc_out", 32'(pc_out), 32'(e.pc));
    end
  endtask

  task automatic consume(input logic rv, input logic [1:0] op, input logic [11:0] tgt,
                         output int waited);
    wait_valid(waited);
    compare_head();
    instr_ready     = 1'b1;
    redirect_valid  = rv;
    redirect_op     = op;
    redirect_target = tgt;
    @(posedge clk); #1;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_op     = OP_NONE;
    redirect_target = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs [16];
    int   w;
    int   base;

    vecs[0]  = '{1'b0, OP_NONE, 12'h000, 12'h002, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, OP_JMP,  12'h010, 12'h010, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, OP_CALL, 12'h200, 12'h200, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, OP_RET,  12'h000, 12'h012, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, OP_NONE, 12'h3A0, 12'h014, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, OP_RET,  12'h000, 12'h016, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, OP_CALL, 12'h100, 12'h100, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, OP_CALL, 12'h120, 12'h120, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, OP_CALL, 12'h140, 12'h140, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, OP_CALL, 12'h160, 12'h160, 1'b0, 1'b1};
    vecs[10] = '{1'b1, OP_CALL, 12'h180, 12'h180, 1'b1, 1'b1};
    vecs[11] = '{1'b1, OP_RET,  12'h000, 12'h142, 1'b1, 1'b1};
    vecs[12] = '{1'b1, OP_RET,  12'h000, 12'h122, 1'b1, 1'b1};
    vecs[13] = '{1'b1, OP_RET,  12'h000, 12'h102, 1'b1, 1'b1};
    vecs[14] = '{1'b1, OP_RET,  12'h000, 12'h018, 1'b1, 1'b1};
    vecs[15] = '{1'b1, OP_JMP,  12'hFFE, 12'hFFE, 1'b1, 1'b1};

    arst_n          = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_op     = OP_NONE;
    redirect_target = '0;
    boot_exit       = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_flash_req", 32'(flash_req), 32'h0);
    check("rst_flash_addr", 32'(flash_addr), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_pc_out", 32'(pc_out), 32'h0);
    check("rst_bootstrapping", 32'(bootstrapping), 32'h1);
    check("rst_stack_ovf", 32'(stack_ovf), 32'h0);
    check("rst_stack_unf", 32'(stack_unf), 32'h0);
    check("rst_fetch_state", 32'(fetch_state), 32'h0);

    // Boot fetch: release reset in cycle 1
    push_exp(12'h000);
    arst_n = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      @(posedge clk); #1;
      case (c)
        2: begin
          check("boot_req_c2", 32'(flash_req), 32'h1);
          check("boot_addr_c2", 32'(flash_addr), 32'h000);
        end
        3: check("boot_req_c3", 32'(flash_req), 32'h0);
        4: begin
          check("boot_req_c4", 32'(flash_req), 32'h1);
          check("boot_addr_c4", 32'(flash_addr), 32'h001);
        end
        5: check("boot_valid_c5", 32'(instr_valid), 32'h0);
        default: begin
          check("boot_valid_c6", 32'(instr_valid), 32'h1);
          check("boot_instr_c6", 32'(instr), 32'h1234);
          check("boot_pc_c6", 32'(pc_out), 32'h000);
        end
      endcase
    end

    // Bootstrap mask: JMP 0x0FE fetches from masked 0x07E/0x07F
    push_exp(12'h0FE);
    base = req_q.size();
    consume(1'b1, OP_JMP, 12'h0FE, w);
    wait_valid(w);
    check("mask_req_count", 32'(req_q.size() - base), 32'd2);
    if (req_q.size() >= base + 2) begin
      check("mask_addr0", 32'(req_q[base]), 32'h07E);
      check("mask_addr1", 32'(req_q[base+1]), 32'h07F);
    end
    compare_head();

    // boot_exit while holding an instruction: restart at 0, unmasked
    boot_exit = 1'b1;
    @(posedge clk); #1;
    boot_exit = 1'b0;
    boot_m    = 1'b0;
    check("bexit_bootstrapping", 32'(bootstrapping), 32'h0);
    check("bexit_valid", 32'(instr_valid), 32'h0);
    check("bexit_state", 32'(fetch_state), 32'h1);
    check("bexit_addr", 32'(flash_addr), 32'h000);
    push_exp(12'h000);

    // Redirect table: CALL/RET, stack overflow/underflow
    for (int i = 0; i < 16; i++) begin
      push_exp(vecs[i].nxt);
      if (i == 15) lat = 3;
      consume(vecs[i].rv, vecs[i].op, vecs[i].tgt, w);
      if (i == 2) check("b2b_wait_cycles", 32'(w), 32'd4);
      check($sformatf("vec%0d_ovf", i), 32'(stack_ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_unf", i), 32'(stack_unf), 32'(vecs[i].unf));
    end

    // Wrap/stall at 0xFFE with 3-cycle flash latency
    wait_valid(w);
    check("slow_wait_cycles", 32'(w), 32'd8);
    redirect_valid  = 1'b1;
    redirect_op     = OP_JMP;
    redirect_target = 12'h3C0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0) check($sformatf("stall_instr%0d", c), 32'(instr), 32'(sb[0].word));
      check($sformatf("stall_valid%0d", c), 32'(instr_valid), 32'h1);
    end
    lat = 1;
    push_exp(12'h000);
    base = req_q.size();
    consume(1'b0, OP_NONE, 12'h000, w);
    wait_valid(w);
    if (req_q.size() > base) check("wrap_addr", 32'(req_q[base]), 32'h000);
    else check("wrap_req_count", 32'(req_q.size() - base), 32'd2);

    // Abort: boot_exit in WAIT of byte 1, stale ready in the following REQ
    lat  = 3;
    base = req_q.size();
    consume(1'b0, OP_NONE, 12'h000, w);
    w = 0;
    while (req_q.size() < base + 2 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("abort_in_wait", 32'(fetch_state), 32'h2);
    boot_exit = 1'b1;
    @(posedge clk); #1;
    boot_exit    = 1'b0;
    inject_ready = 1'b1;
    check("abort_valid", 32'(instr_valid), 32'h0);
    check("abort_state", 32'(fetch_state), 32'h1);
    check("abort_addr", 32'(flash_addr), 32'h000);
    @(posedge clk); #1;
    inject_ready = 1'b0;
    check("abort_stale_state", 32'(fetch_state), 32'h2);
    check("abort_stale_valid", 32'(instr_valid), 32'h0);
    push_exp(12'h000);
    consume(1'b0, OP_NONE, 12'h000, w);

    // Reset mid-fetch
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", 32'(fetch_state), 32'h0);
    check("midrst_req", 32'(flash_req), 32'h0);
    check("midrst_valid", 32'(instr_valid), 32'h0);
    check("midrst_instr", 32'(instr), 32'h0);
    check("midrst_boot", 32'(bootstrapping), 32'h1);
    check("midrst_ovf", 32'(stack_ovf), 32'h0);
    check("midrst_unf", 32'(stack_unf), 32'h0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction front-end for the 8-bit microcontroller family. It replaces the fixed 12-bit program counter and the bootstrap address masking with a configurable unit. The unit fetches INSTR_BYTES flash bytes per instruction and assembles them big-endian into one instruction word. It presents that word to the control unit over a valid/ready handshake and supports jump, call and return through an internal return-address stack. It sits between the flash port and the control unit in the top level.

## Interface
- ADDR_WIDTH, 12, flash byte-address and PC width
- BYTE_WIDTH, 8, flash data width
- INSTR_BYTES, 2, bytes per instruction (≥1); instruction width = BYTE_WIDTH*INSTR_BYTES
- STACK_DEPTH, 4, return-stack entries (≥1)
- BOOT_MASK, 'h07F, AND-mask applied to flash_addr while bootstrapping

- clk  in  1  single clock, rising edge
- arst_n  in  1  reset; synchronous and active-low
- flash_data  in  BYTE_WIDTH  byte returned by flash
- flash_ready  in  1  flash_data valid this cycle
- flash_req  out  1  one-cycle request strobe
- flash_addr  out  ADDR_WIDTH  requested byte address
- instr  out  BYTE_WIDTH*INSTR_BYTES  assembled instruction
- instr_valid  out  1  instr and pc_out valid
- instr_ready  in  1  control unit consumes instr
- pc_out  out  ADDR_WIDTH  byte address of the instruction in instr
- redirect_valid  in  1  redirect request, sampled only on handshake cycles
- redirect_op  in  2  01 JMP, 10 CALL, 11 RET, 00 none
- redirect_target  in  ADDR_WIDTH  JMP/CALL destination
- boot_exit  in  1  pulse: leave bootstrap mode
- bootstrapping  out  1  bootstrap mode active
- stack_ovf, stack_unf  out  1 each  sticky error flags
- fetch_state  out  2  debug: IDLE=0, REQ=1, WAIT=2, HOLD=3

## Operation
- FSM states:
  - IDLE → REQ unconditionally.
  - REQ: flash_req=1 → WAIT.
  - WAIT: on flash_ready, capture the byte. If byte_cnt==INSTR_BYTES-1 → HOLD, otherwise byte_cnt++ → REQ.
  - HOLD: instr_valid=1; on instr_ready → REQ with byte_cnt=0.
- flash_addr = (pc + byte_cnt) mod 2^ADDR_WIDTH, ANDed with BOOT_MASK while bootstrapping=1. It is registered and held stable through REQ and WAIT.
- Byte k is placed at instr bits [(INSTR_BYTES-k)*BYTE_WIDTH-1 -: BYTE_WIDTH], so the first byte lands in the MSBs.
- flash_ready outside WAIT is ignored.
- On a handshake (instr_valid && instr_ready), the next pc is chosen as follows:
  - none, or redirect_valid=0: pc+INSTR_BYTES.
  - JMP: redirect_target.
  - CALL: push pc+INSTR_BYTES, then go to redirect_target.
  - RET: pop the stack.
- All pc arithmetic wraps modulo 2^ADDR_WIDTH.
- CALL with the stack full: the jump is still taken, the stack is unchanged, and stack_ovf is set.
- RET with the stack empty: pc = pc+INSTR_BYTES and stack_unf is set.
- Flags clear only on reset.
- redirect_valid without a handshake is ignored.
- boot_exit, in any state, takes effect on the next edge:
  - bootstrapping=0 and pc=0;
  - the stack is emptied and byte_cnt=0;
  - any partial instruction is discarded, instr_valid drops, and the FSM goes to REQ.
- boot_exit has priority over a simultaneous handshake or redirect.
- boot_exit while already out of bootstrap performs the same restart.

## Timing
- Reset values:
  - state IDLE, pc 0, byte_cnt 0;
  - flash_req 0, flash_addr 0, instr 0, instr_valid 0, pc_out 0;
  - bootstrapping 1, stack empty, stack_ovf 0, stack_unf 0, fetch_state 0.
- Reset asserted mid-fetch aborts the fetch and returns to the reset values on the next edge.
- First flash_req occurs in the 2nd cycle after reset release.
- Best-case fetch with flash_ready one cycle after the request: 2*INSTR_BYTES cycles from the first REQ to the capture edge; instr_valid rises the following cycle.
- Back-to-back throughput: 2*INSTR_BYTES+1 cycles per instruction, including the HOLD cycle.
- flash_req is high for exactly one cycle per byte.
- instr, pc_out and instr_valid are registered. They change only on the capture edge, the handshake edge or boot_exit.

## Structure
- Package fetch_pkg holds:
  - state encodings (IDLE/REQ/WAIT/HOLD);
  - redirect opcodes (OP_NONE/OP_JMP/OP_CALL/OP_RET).
- Sub-module ret_stack: a LIFO of STACK_DEPTH × ADDR_WIDTH.
  - Ports: push, pop, din, dout, full, empty, clear.
  - Synchronous active-low reset.
  - Push when full and pop when empty are no-ops; the parent detects both.

## Test plan
- **Reset/boot fetch:** release reset; flash returns 0x12,0x34 with a 1-cycle delay.
  - flash_addr 0x000 then 0x001.
  - instr=0x1234, pc_out=0x000, instr_valid in cycle 6.
- **Bootstrap mask:** JMP to 0x0FE while bootstrapping.
  - flash_addr 0x07E, 0x07F.
  - After boot_exit: flash_addr 0x000, bootstrapping=0.
- **Call/return:** CALL 0x200 at pc 0x010 → next fetch 0x200; RET → next fetch 0x012.
- **Stack limits:**
  - 5 CALLs with STACK_DEPTH=4: stack_ovf=1 after the 5th, and the 5th target is still fetched.
  - RET on an empty stack: pc advances by 2 and stack_unf=1.
- **Wrap/stall:** pc 0xFFE with a 3-cycle flash_ready delay and instr_ready held low 4 cycles.
  - instr is held stable throughout the stall.
  - Next fetch at 0x000.
- **Abort:** boot_exit asserted in WAIT after byte 0 → instr_valid stays 0, restart at 0x000, and a stale flash_ready is ignored.
